acp_ram_subunit: RTL and testbench

Load/store subunit that sits directly downstream of the core's load/store unit address decode and serves every access falling in the ACP RAM window (0x0003_0000–0x0003_0080). It registers one request at a time and converts it into a single-beat AXI4-Lite read or write toward the ACP port. It returns exactly one tagged response per request to the load/store writeback path. Out-of-window requests are answered locally with an error and never reach the bus.

---
 rtl/acp_ram_subunit.sv | 224 ++++++++++++++++++++++
 tb/tb_acp_ram_subunit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acp_ram_subunit.sv
// ACP RAM window load/store subunit: one request at a time, bridged to a single-beat
// AXI4-Lite read or write, with one tagged response per request.
module acp_ram_subunit #(
  parameter logic [31:0] ADDR_L    = 32'h0003_0000,
  parameter logic [31:0] ADDR_H    = 32'h0003_0080,
  parameter int unsigned BIT_CHECK = 16,
  parameter int unsigned ID_W      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_addr,
  input  logic            req_we,
  input  logic [3:0]      req_be,
  input  logic [31:0]     req_wdata,
  input  logic [ID_W-1:0] req_id,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_data,
  output logic [ID_W-1:0] rsp_id,
  output logic            rsp_err,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [31:0]     m_awaddr,
  output logic            m_wvalid,
  input  logic            m_wready,
  output logic [31:0]     m_wdata,
  output logic [3:0]      m_wstrb,
  input  logic            m_bvalid,
  output logic            m_bready,
  input  logic [1:0]      m_bresp,
  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [31:0]     m_araddr,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  output logic            busy
);

  localparam int unsigned CHK_LO = 32 - BIT_CHECK;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic            req_ready_q, req_ready_d;
  logic            busy_q, busy_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic            rsp_err_q, rsp_err_d;

  logic in_win_c;
  logic aw_done_c;
  logic w_done_c;

  // Coarse upper-bit match plus exact inclusive range check
  assign in_win_c = (req_addr[31:CHK_LO] == ADDR_L[31:CHK_LO]) &&
                    (req_addr >= ADDR_L) && (req_addr <= ADDR_H);

  // A channel is done once its valid has dropped or it handshakes this cycle
  assign aw_done_c = !awvalid_q || m_awready;
  assign w_done_c  = !wvalid_q  || m_wready;

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d      = {req_addr[31:2], 2'b00};
          wdata_d     = req_wdata;
          wstrb_d     = req_be;
          rsp_id_d    = req_id;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (!in_win_c) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 32'd0;
          end else if (req_we) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (awvalid_q && m_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
        if (aw_done_c && w_done_c) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_bvalid) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (m_bresp != 2'b00);
          rsp_data_d  = 32'd0;
        end
      end
      RD_REQ: begin
        if (m_arready) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (m_rvalid) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (m_rresp != 2'b00);
          rsp_data_d  = m_rdata;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_id_q    <= ID_W'(0);
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign m_awvalid = awvalid_q;
  assign m_awaddr  = addr_q;
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_bready  = bready_q;
  assign m_arvalid = arvalid_q;
  assign m_araddr  = addr_q;
  assign m_rready  = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_acp_ram_subunit.sv
// Randomized bench for acp_ram_subunit: AXI slave with programmable stalls and a
// transaction-level expectation of every response.
module tb_acp_ram_subunit;

  localparam logic [31:0] ADDR_L = 32'h0003_0000;
  localparam logic [31:0] ADDR_H = 32'h0003_0080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic [2:0]  req_id;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_id;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        busy;

  acp_ram_subunit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_be(req_be), .req_wdata(req_wdata), .req_id(req_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave behaviour knobs, set by the stimulus process
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, resp_dly = 0;
  logic [31:0] slv_rdata = 32'd0;
  logic [1:0]  slv_rresp = 2'd0, slv_bresp = 2'd0;

  // Monitor state, written only at posedge
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, vld_cyc = 0, proto_err = 0;
  logic [31:0] last_awaddr = 0, last_wdata = 0, last_araddr = 0;
  logic [3:0]  last_wstrb = 0;
  logic        rd_pend = 0, wr_pend = 0, aw_seen = 0, w_seen = 0;
  logic        st_aw = 0, st_w = 0, st_ar = 0;
  logic [31:0] st_awaddr = 0, st_wdata = 0, st_araddr = 0;
  logic [3:0]  st_wstrb = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_pend = 0; wr_pend = 0; aw_seen = 0; w_seen = 0;
      st_aw = 0; st_w = 0; st_ar = 0;
    end else begin
      if (m_arvalid || m_awvalid || m_wvalid) vld_cyc++;
      if (st_ar && (!m_arvalid || m_araddr !== st_araddr)) proto_err++;
      if (st_aw && (!m_awvalid || m_awaddr !== st_awaddr)) proto_err++;
      if (st_w && (!m_wvalid || m_wdata !== st_wdata || m_wstrb !== st_wstrb)) proto_err++;
      st_ar = m_arvalid && !m_arready; st_araddr = m_araddr;
      st_aw = m_awvalid && !m_awready; st_awaddr = m_awaddr;
      st_w  = m_wvalid && !m_wready;   st_wdata = m_wdata; st_wstrb = m_wstrb;
      if (m_arvalid && m_arready) begin ar_hs++; last_araddr = m_araddr; rd_pend = 1; end
      if (m_rvalid && m_rready) begin r_hs++; rd_pend = 0; end
      if (m_awvalid && m_awready) begin aw_hs++; last_awaddr = m_awaddr; aw_seen = 1; end
      if (m_wvalid && m_wready) begin
        w_hs++; last_wdata = m_wdata; last_wstrb = m_wstrb; w_seen = 1;
      end
      if (m_bvalid && m_bready) begin b_hs++; wr_pend = 0; end
      if (aw_seen && w_seen) begin wr_pend = 1; aw_seen = 0; w_seen = 0; end
    end
  end

  // Slave drive on the falling edge; valids held until their handshake
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, b_cnt = 0;
  always @(negedge clk) begin
    if (m_awvalid) begin m_awready = (aw_cnt >= aw_dly); aw_cnt++; end
    else begin m_awready = 0; aw_cnt = 0; end
    if (m_wvalid) begin m_wready = (w_cnt >= w_dly); w_cnt++; end
    else begin m_wready = 0; w_cnt = 0; end
    if (m_arvalid) begin m_arready = (ar_cnt >= ar_dly); ar_cnt++; end
    else begin m_arready = 0; ar_cnt = 0; end
    if (rd_pend) begin
      if (!m_rvalid) begin
        if (r_cnt >= resp_dly) begin m_rvalid = 1; m_rdata = slv_rdata; m_rresp = slv_rresp; end
        else r_cnt++;
      end
    end else begin m_rvalid = 0; r_cnt = 0; end
    if (wr_pend) begin
      if (!m_bvalid) begin
        if (b_cnt >= resp_dly) begin m_bvalid = 1; m_bresp = slv_bresp; end
        else b_cnt++;
      end
    end else begin m_bvalid = 0; b_cnt = 0; end
  end

  // One request through to its response handshake, checked against the transaction model
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [2:0] id, input int hold,
                         input int exp_lat);
    int          aw0, w0, ar0, b0, r0, v0, lat, vh;
    bit          got, inwin;
    logic [31:0] e_data;
    logic        e_err;
    inwin = (addr >= ADDR_L) && (addr <= ADDR_H);
    if (!inwin)  begin e_data = 32'd0;     e_err = 1'b1; end
    else if (we) begin e_data = 32'd0;     e_err = (slv_bresp != 2'd0); end
    else         begin e_data = slv_rdata; e_err = (slv_rresp != 2'd0); end
    aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; b0 = b_hs; r0 = r_hs; v0 = vld_cyc;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_addr = addr; req_we = we; req_be = be; req_wdata = wdata; req_id = id;
    @(posedge clk); #1;
    // Keep a junk request pending; it must not be accepted until the response completes
    req_addr = $urandom; req_we = 1'($urandom); req_wdata = $urandom; req_id = 3'($urandom);
    got = 0; lat = 0;
    for (int i = 1; i <= 80 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; lat = i; end
      else check("req_ready_busy", 32'(req_ready), 32'd0);
    end
    if (!got) begin
      check("rsp_timeout", 32'd0, 32'd1);
      req_valid = 0;
      return;
    end
    if (!inwin)        check("oow_latency", 32'(lat), 32'd1);
    else if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_data", rsp_data, e_data);
    check("rsp_err", 32'(rsp_err), 32'(e_err));
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("busy_rsp", 32'(busy), 32'd1);
    check("aw_count", 32'(aw_hs - aw0), (inwin && we) ? 32'd1 : 32'd0);
    check("w_count",  32'(w_hs - w0),   (inwin && we) ? 32'd1 : 32'd0);
    check("b_count",  32'(b_hs - b0),   (inwin && we) ? 32'd1 : 32'd0);
    check("ar_count", 32'(ar_hs - ar0), (inwin && !we) ? 32'd1 : 32'd0);
    check("r_count",  32'(r_hs - r0),   (inwin && !we) ? 32'd1 : 32'd0);
    if (!inwin) check("oow_no_valid", 32'(vld_cyc - v0), 32'd0);
    else if (we) begin
      check("awaddr", last_awaddr, addr & 32'hFFFF_FFFC);
      check("wdata", last_wdata, wdata);
      check("wstrb", 32'(last_wstrb), 32'(be));
    end else check("araddr", last_araddr, addr & 32'hFFFF_FFFC);
    vh = vld_cyc;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", rsp_data, e_data);
      check("hold_err_id", {28'd0, rsp_err, rsp_id}, {28'd0, e_err, id});
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    check("hold_no_axi", 32'(vld_cyc - vh), 32'd0);
    rsp_ready = 1; req_valid = 0;
    @(negedge clk);
    rsp_ready = 0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  logic [31:0] a;
  initial begin
    rst_n = 0; req_valid = 0; req_addr = 0; req_we = 0; req_be = 0; req_wdata = 0; req_id = 0;
    rsp_ready = 0; m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_valids", {25'd0, busy, rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 32'd0);
    check("rst_rsp", {rsp_data[31:4] | 28'(rsp_id), rsp_data[3:0] | {3'd0, rsp_err}}, 32'd0);
    check("rst_bus", m_awaddr | m_araddr | m_wdata | 32'(m_wstrb), 32'd0);
    @(negedge clk); rst_n = 1;

    // Minimum-latency load
    slv_rdata = 32'hDEADBEEF; slv_rresp = 0;
    run_txn(32'h0003_0004, 0, 4'h0, 32'h0, 3'd5, 0, 3);
    // Store with aw accepted two cycles before w
    aw_dly = 0; w_dly = 2; slv_bresp = 0;
    run_txn(32'h0003_0043, 1, 4'b1000, 32'h11223344, 3'd2, 0, 0);
    w_dly = 0;
    // Out-of-window
    run_txn(32'h0003_0084, 0, 4'h0, 32'h0, 3'd1, 0, 0);
    run_txn(32'h0004_0000, 1, 4'hF, 32'hCAFE0000, 3'd6, 0, 0);
    // Window edges; minimum-latency store; read error keeps rdata
    run_txn(32'h0003_0000, 1, 4'h3, 32'hA5A5_5A5A, 3'd7, 0, 3);
    slv_rdata = 32'h1234_5678; slv_rresp = 2'b10;
    run_txn(32'h0003_0080, 0, 4'h0, 32'h0, 3'd3, 0, 3);
    // Response stalled five cycles
    slv_rresp = 0; slv_rdata = 32'h0BAD_F00D;
    run_txn(32'h0003_0010, 0, 4'h0, 32'h0, 3'd4, 5, 3);

    // Reset while a read address is pending
    ar_dly = 20;
    @(negedge clk);
    req_valid = 1; req_addr = 32'h0003_0020; req_we = 0; req_id = 3'd1;
    @(posedge clk); #1; req_valid = 0;
    @(negedge clk);
    check("arvalid_before_rst", 32'(m_arvalid), 32'd1);
    rst_n = 0; #1;
    check("arvalid_in_rst", 32'(m_arvalid), 32'd0);
    check("busy_in_rst", 32'(busy), 32'd0);
    check("req_ready_in_rst", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1; ar_dly = 0; slv_rdata = 32'h0055_AA00;
    run_txn(32'h0003_0020, 0, 4'h0, 32'h0, 3'd0, 0, 3);

    // Randomized traffic with random stalls and responses
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: a = ADDR_L + 32'($urandom_range(0, 128));
        1: a = ADDR_H + 32'($urandom_range(1, 16));
        2: a = ADDR_L - 32'($urandom_range(1, 16));
        default: a = $urandom;
      endcase
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); resp_dly = $urandom_range(0, 3);
      slv_rdata = $urandom; slv_rresp = 2'($urandom); slv_bresp = 2'($urandom);
      run_txn(a, 1'($urandom), 4'($urandom), $urandom, 3'($urandom),
              $urandom_range(0, 3), 0);
    end

    check("axi_stable", 32'(proto_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
